riscv_rd_arb: RTL and testbench

RISCV_RD_ARB -- requirements
Module: riscv_rd_arb

---
 rtl/riscv_rd_arb_if.sv | 21 ++
 rtl/riscv_rd_arb.sv | 129 ++++++++++++
 tb/tb_riscv_rd_arb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_rd_arb_if.sv
// Read channel bundle: request (vld/addr/ack) plus in-order response (vld/addr/data/ack).
// master issues requests and accepts responses; slave accepts requests and returns responses.
interface riscv_rd_arb_if;
  logic        req_vld;
  logic [31:0] req_addr;
  logic        req_ack;
  logic        rsp_vld;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_ack;

  modport master (
    output req_vld, req_addr, rsp_ack,
    input  req_ack, rsp_vld, rsp_addr, rsp_data
  );

  modport slave (
    input  req_vld, req_addr, rsp_ack,
    output req_ack, rsp_vld, rsp_addr, rsp_data
  );
endinterface

// File: rtl/riscv_rd_arb.sv
// Shares one in-order memory read port between IFU and LSU, tracking response owners in a FIFO.
// Define RISCV_RD_ARB_AGE_EN to build the IFU starvation guard (AGE_LIMIT wait cycles).
module riscv_rd_arb #(
  parameter int OWNQ_DEPTH = 4,
  parameter int AGE_LIMIT  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  riscv_rd_arb_if.slave               ifu,
  riscv_rd_arb_if.slave               lsu,
  riscv_rd_arb_if.master              mem,
  input  logic                        ifu_flush,
  output logic [$clog2(OWNQ_DEPTH):0] arb_outstanding,
  output logic                        arb_err
);

  localparam int PW = $clog2(OWNQ_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OWNQ_DEPTH);

  logic [OWNQ_DEPTH-1:0] own_q;
  logic [OWNQ_DEPTH-1:0] drop_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

  logic full;
  logic empty;
  logic ifu_live;
  logic lsu_live;
  logic age_pri;
  logic grant_lsu;
  logic grant_ifu;
  logic push;
  logic pop;
  logic head_own;
  logic head_drop;
  logic rsp_to_ifu;
  logic rsp_to_lsu;

  assign full            = (count == DEPTH_C);
  assign empty           = (count == '0);
  assign arb_outstanding = count;

  // Requests and acks are qualified by reset so every handshake output is low while held in reset.
  always_comb begin
    ifu_live     = ifu.req_vld & ~ifu_flush & reset;
    lsu_live     = lsu.req_vld & reset;
    grant_lsu    = lsu_live & ~(age_pri & ifu_live);
    grant_ifu    = ifu_live & ~grant_lsu;
    mem.req_vld  = (ifu_live | lsu_live) & ~full;
    mem.req_addr = grant_lsu ? lsu.req_addr : ifu.req_addr;
    lsu.req_ack  = mem.req_ack & grant_lsu & ~full;
    ifu.req_ack  = mem.req_ack & grant_ifu & ~full;
    push         = mem.req_vld & mem.req_ack;

    head_own   = own_q[rd_ptr];
    head_drop  = drop_q[rd_ptr];
    rsp_to_lsu = ~empty & head_own;
    rsp_to_ifu = ~empty & ~head_own & ~head_drop & ~ifu_flush;

    ifu.rsp_vld  = mem.rsp_vld & rsp_to_ifu;
    ifu.rsp_addr = mem.rsp_addr;
    ifu.rsp_data = mem.rsp_data;
    lsu.rsp_vld  = mem.rsp_vld & rsp_to_lsu;
    lsu.rsp_addr = mem.rsp_addr;
    lsu.rsp_data = mem.rsp_data;

    // Dropped IFU reads and orphan responses are sunk unconditionally.
    if (rsp_to_lsu)      mem.rsp_ack = lsu.rsp_ack;
    else if (rsp_to_ifu) mem.rsp_ack = ifu.rsp_ack;
    else                 mem.rsp_ack = reset;

    pop = mem.rsp_vld & mem.rsp_ack & ~empty;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      own_q   <= '0;
      drop_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      arb_err <= 1'b0;
    end else begin
      if (mem.rsp_vld & empty) arb_err <= 1'b1;

      for (int i = 0; i < OWNQ_DEPTH; i++) begin
        if (ifu_flush & ~own_q[i]) drop_q[i] <= 1'b1;
      end

      // A flush never grants IFU, so a same-cycle push cannot be an IFU entry needing a drop.
      if (push) begin
        own_q[wr_ptr]  <= grant_lsu;
        drop_q[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + 1'b1;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RISCV_RD_ARB_AGE_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

  logic [AW-1:0] age_cnt;

  assign age_pri = (age_cnt == AGE_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age_cnt <= '0;
    end else if (~ifu.req_vld | ifu.req_ack) begin
      age_cnt <= '0;
    end else if (~ifu_flush && (age_cnt != AGE_MAX)) begin
      age_cnt <= age_cnt + 1'b1;
    end
  end
`else
  assign age_pri = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_rd_arb.sv
// Directed bench for riscv_rd_arb with a queue-based reference model checked every cycle.
// Build with RISCV_RD_ARB_AGE_EN defined to exercise the IFU aging scenario.
module tb_riscv_rd_arb;
  localparam int DEPTH = 4;
  localparam int AGE   = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ifu_flush;
  logic [2:0] arb_outstanding;
  logic       arb_err;

  riscv_rd_arb_if ifu_bus ();
  riscv_rd_arb_if lsu_bus ();
  riscv_rd_arb_if mem_bus ();

  riscv_rd_arb #(.OWNQ_DEPTH(DEPTH), .AGE_LIMIT(AGE)) dut (
    .clock           (clock),
    .reset           (reset),
    .ifu             (ifu_bus),
    .lsu             (lsu_bus),
    .mem             (mem_bus),
    .ifu_flush       (ifu_flush),
    .arb_outstanding (arb_outstanding),
    .arb_err         (arb_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ownership queue, sticky error, IFU wait counter.
  typedef struct packed {logic owner; logic drop;} ent_t;
  ent_t mq[$];
  bit   m_err;
  int   m_age;

  function automatic bit e_ifu_live();
    return ifu_bus.req_vld && !ifu_flush;
  endfunction

  function automatic bit e_lsu_win();
    bit age_pri = 1'b0;
`ifdef RISCV_RD_ARB_AGE_EN
    age_pri = (m_age == AGE);
`endif
    return lsu_bus.req_vld && !(age_pri && e_ifu_live());
  endfunction

  function automatic bit e_mem_vld();
    return (e_ifu_live() || lsu_bus.req_vld) && (mq.size() < DEPTH);
  endfunction

  function automatic bit e_ifu_ack();
    return e_mem_vld() && e_ifu_live() && !e_lsu_win() && mem_bus.req_ack;
  endfunction

  function automatic bit e_lsu_ack();
    return e_mem_vld() && e_lsu_win() && mem_bus.req_ack;
  endfunction

  // 0: sink silently, 1: IFU, 2: LSU, 3: queue empty (error sink)
  function automatic int e_route();
    if (mq.size() == 0) return 3;
    if (mq[0].owner) return 2;
    if (!mq[0].drop && !ifu_flush) return 1;
    return 0;
  endfunction

  function automatic bit e_rsp_ack();
    case (e_route())
      1:       return ifu_bus.rsp_ack;
      2:       return lsu_bus.rsp_ack;
      default: return 1'b1;
    endcase
  endfunction

  bit   p_push, p_own, p_pop, p_ifu_ack;
  int   p_route;
  ent_t p_ent;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_err = 1'b0;
      m_age = 0;
    end else begin
      p_push    = e_mem_vld() && mem_bus.req_ack;
      p_own     = e_lsu_win();
      p_route   = e_route();
      p_pop     = mem_bus.rsp_vld && (p_route != 3) && e_rsp_ack();
      p_ifu_ack = e_ifu_ack();
      if (mem_bus.rsp_vld && p_route == 3) m_err = 1'b1;
      if (ifu_flush) foreach (mq[i]) if (!mq[i].owner) mq[i].drop = 1'b1;
      if (p_pop) void'(mq.pop_front());
      if (p_push) begin
        p_ent.owner = p_own;
        p_ent.drop  = 1'b0;
        mq.push_back(p_ent);
      end
      if (!ifu_bus.req_vld || p_ifu_ack) m_age = 0;
      else if (!ifu_flush && m_age < AGE) m_age++;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("rst_mem_req_vld", mem_bus.req_vld, 0);
      check("rst_ifu_req_ack", ifu_bus.req_ack, 0);
      check("rst_lsu_req_ack", lsu_bus.req_ack, 0);
      check("rst_ifu_rsp_vld", ifu_bus.rsp_vld, 0);
      check("rst_lsu_rsp_vld", lsu_bus.rsp_vld, 0);
      check("rst_mem_rsp_ack", mem_bus.rsp_ack, 0);
      check("rst_outstanding", arb_outstanding, 0);
      check("rst_err", arb_err, 0);
    end else begin
      check("mem_req_vld", mem_bus.req_vld, e_mem_vld());
      if (e_mem_vld())
        check("mem_req_addr", mem_bus.req_addr,
              e_lsu_win() ? lsu_bus.req_addr : ifu_bus.req_addr);
      check("ifu_req_ack", ifu_bus.req_ack, e_ifu_ack());
      check("lsu_req_ack", lsu_bus.req_ack, e_lsu_ack());
      check("outstanding", arb_outstanding, mq.size());
      check("arb_err", arb_err, m_err);
      check("ifu_rsp_vld", ifu_bus.rsp_vld, mem_bus.rsp_vld && e_route() == 1);
      check("lsu_rsp_vld", lsu_bus.rsp_vld, mem_bus.rsp_vld && e_route() == 2);
      if (mem_bus.rsp_vld) begin
        check("mem_rsp_ack", mem_bus.rsp_ack, e_rsp_ack());
        if (e_route() == 1) begin
          check("ifu_rsp_addr", ifu_bus.rsp_addr, mem_bus.rsp_addr);
          check("ifu_rsp_data", ifu_bus.rsp_data, mem_bus.rsp_data);
        end
        if (e_route() == 2) begin
          check("lsu_rsp_addr", lsu_bus.rsp_addr, mem_bus.rsp_addr);
          check("lsu_rsp_data", lsu_bus.rsp_data, mem_bus.rsp_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ifu_bus.req_vld  = 1'b0;
    ifu_bus.req_addr = '0;
    ifu_bus.rsp_ack  = 1'b0;
    lsu_bus.req_vld  = 1'b0;
    lsu_bus.req_addr = '0;
    lsu_bus.rsp_ack  = 1'b0;
    mem_bus.req_ack  = 1'b0;
    mem_bus.rsp_vld  = 1'b0;
    mem_bus.rsp_addr = '0;
    mem_bus.rsp_data = '0;
    ifu_flush        = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit route_ifu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit exp_age_ack;

  initial begin
    idle();
    #1 reset = 1'b0;
    // Requests presented during reset must not be acknowledged.
    ifu_bus.req_vld  = 1'b1;
    ifu_bus.req_addr = 32'h0000_0040;
    mem_bus.req_ack  = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    check("lit_rst_ifu_ack", ifu_bus.req_ack, 0);
    check("lit_rst_outstanding", arb_outstanding, 0);
    tick();
    idle();
    reset = 1'b1;

    // Both requesters, empty queue: LSU wins.
    tick();
    ifu_bus.req_vld  = 1'b1;
    ifu_bus.req_addr = 32'h0000_1000;
    lsu_bus.req_vld  = 1'b1;
    lsu_bus.req_addr = 32'h0000_2000;
    mem_bus.req_ack  = 1'b1;
    @(negedge clock);
    check("lit_both_lsu_ack", lsu_bus.req_ack, 1);
    check("lit_both_ifu_ack", ifu_bus.req_ack, 0);
    check("lit_both_addr", mem_bus.req_addr, 32'h0000_2000);
    check("lit_both_out0", arb_outstanding, 0);
    tick();
    idle();
    @(negedge clock);
    check("lit_both_out1", arb_outstanding, 1);
    tick();
    mem_bus.rsp_vld  = 1'b1;
    mem_bus.rsp_addr = 32'h0000_2000;
    mem_bus.rsp_data = 32'h0000_0011;
    lsu_bus.rsp_ack  = 1'b1;
    @(negedge clock);
    check("lit_rsp_lsu_vld", lsu_bus.rsp_vld, 1);
    check("lit_rsp_lsu_data", lsu_bus.rsp_data, 32'h0000_0011);
    check("lit_rsp_mem_ack", mem_bus.rsp_ack, 1);
    tick();
    idle();
    @(negedge clock);
    check("lit_rsp_out0", arb_outstanding, 0);

    // Fill the queue IFU,LSU,IFU,LSU then drain in order.
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      mem_bus.req_ack = 1'b1;
      if (k % 2 == 0) begin
        ifu_bus.req_vld  = 1'b1;
        ifu_bus.req_addr = 32'h100 + 32'(k * 4);
      end else begin
        lsu_bus.req_vld  = 1'b1;
        lsu_bus.req_addr = 32'h200 + 32'(k * 4);
      end
    end
    tick();
    ifu_bus.req_vld = 1'b1;
    lsu_bus.req_vld = 1'b1;
    mem_bus.req_ack = 1'b1;
    @(negedge clock);
    check("lit_full_mem_vld", mem_bus.req_vld, 0);
    check("lit_full_ifu_ack", ifu_bus.req_ack, 0);
    check("lit_full_lsu_ack", lsu_bus.req_ack, 0);
    check("lit_full_out", arb_outstanding, 4);
    tick();
    idle();
    mem_bus.rsp_vld = 1'b1;
    lsu_bus.rsp_ack = 1'b1;
    @(negedge clock);
    check("lit_bp_ifu_vld", ifu_bus.rsp_vld, 1);
    check("lit_bp_mem_ack", mem_bus.rsp_ack, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      mem_bus.rsp_vld  = 1'b1;
      mem_bus.rsp_addr = 32'h300 + 32'(k);
      mem_bus.rsp_data = 32'hA0 + 32'(k);
      ifu_bus.rsp_ack  = 1'b1;
      lsu_bus.rsp_ack  = 1'b1;
      @(negedge clock);
      check("lit_order_ifu", ifu_bus.rsp_vld, route_ifu[k]);
      check("lit_order_lsu", lsu_bus.rsp_vld, !route_ifu[k]);
      check("lit_order_out", arb_outstanding, 4 - k);
    end
    tick();
    idle();
    @(negedge clock);
    check("lit_drain_out", arb_outstanding, 0);

    // Two IFU reads, flush, responses silently consumed.
    tick();
    ifu_bus.req_vld  = 1'b1;
    ifu_bus.req_addr = 32'h0000_0300;
    mem_bus.req_ack  = 1'b1;
    tick();
    ifu_bus.req_addr = 32'h0000_0304;
    tick();
    ifu_flush = 1'b1;
    @(negedge clock);
    check("lit_flush_ifu_ack", ifu_bus.req_ack, 0);
    check("lit_flush_mem_vld", mem_bus.req_vld, 0);
    check("lit_flush_out", arb_outstanding, 2);
    for (int k = 0; k < 2; k++) begin
      tick();
      idle();
      mem_bus.rsp_vld  = 1'b1;
      mem_bus.rsp_data = 32'hBEEF + 32'(k);
      @(negedge clock);
      check("lit_drop_ifu_vld", ifu_bus.rsp_vld, 0);
      check("lit_drop_mem_ack", mem_bus.rsp_ack, 1);
    end
    tick();
    idle();
    @(negedge clock);
    check("lit_drop_out", arb_outstanding, 0);
    check("lit_drop_err", arb_err, 0);

    // Orphan response sets the sticky error.
    tick();
    mem_bus.rsp_vld = 1'b1;
    @(negedge clock);
    check("lit_orphan_ack", mem_bus.rsp_ack, 1);
    check("lit_orphan_lsu", lsu_bus.rsp_vld, 0);
    tick();
    idle();
    @(negedge clock);
    check("lit_err_set", arb_err, 1);
    repeat (3) tick();
    @(negedge clock);
    check("lit_err_sticky", arb_err, 1);
    tick();
    reset = 1'b0;
    #1;
    check("lit_err_clr", arb_err, 0);
    tick();
    reset = 1'b1;

    // Reset mid-transaction with three entries outstanding.
    tick();
    lsu_bus.req_vld  = 1'b1;
    lsu_bus.req_addr = 32'h0000_0400;
    mem_bus.req_ack  = 1'b1;
    repeat (3) tick();
    #1;
    check("lit_pre_rst_out", arb_outstanding, 3);
    reset = 1'b0;
    #1;
    check("lit_async_out", arb_outstanding, 0);
    check("lit_async_lsu_ack", lsu_bus.req_ack, 0);
    check("lit_async_mem_vld", mem_bus.req_vld, 0);
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();
    mem_bus.rsp_vld = 1'b1;
    @(negedge clock);
    check("lit_post_rst_ack", mem_bus.rsp_ack, 1);
    tick();
    idle();
    @(negedge clock);
    check("lit_post_rst_err", arb_err, 1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Continuous contention with a responder returning one read per cycle.
    tick();
    ifu_bus.req_vld  = 1'b1;
    ifu_bus.req_addr = 32'h0000_0500;
    lsu_bus.req_vld  = 1'b1;
    lsu_bus.req_addr = 32'h0000_0600;
    mem_bus.req_ack  = 1'b1;
    ifu_bus.rsp_ack  = 1'b1;
    lsu_bus.rsp_ack  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      mem_bus.rsp_vld  = (mq.size() > 0);
      mem_bus.rsp_addr = 32'h700 + 32'(c);
      mem_bus.rsp_data = 32'h800 + 32'(c);
`ifdef RISCV_RD_ARB_AGE_EN
      exp_age_ack = (c == 8);
`else
      exp_age_ack = 1'b0;
`endif
      @(negedge clock);
      check("lit_age_ifu_ack", ifu_bus.req_ack, exp_age_ack);
      check("lit_age_lsu_ack", lsu_bus.req_ack, !exp_age_ack);
      tick();
    end
    idle();
    ifu_bus.rsp_ack = 1'b1;
    lsu_bus.rsp_ack = 1'b1;
    for (int c = 0; c < 8 && mq.size() > 0; c++) begin
      mem_bus.rsp_vld = 1'b1;
      tick();
    end
    idle();
    @(negedge clock);
    check("lit_final_out", arb_outstanding, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
